// File: rtl/onehot_event_gen_pkg.sv
// Shared constants and helpers for the one-hot event front end.
// highest_onehot() doubles as a reference model for the downstream encoder bench.
package onehot_event_gen_pkg;

    localparam int N_REQ           = 4;
    localparam int SYNC_STAGES_DEF = 2;

    // One-hot mask of the highest set bit, or all-zero when nothing is set.
    function automatic logic [N_REQ-1:0] highest_onehot(input logic [N_REQ-1:0] v);
        logic [N_REQ-1:0] m;
        m = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (v[i]) begin
                m    = '0;
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/onehot_event_gen_if.sv
// Event handshake between the front end (master) and the 4-to-2 encoder (slave).
interface onehot_event_gen_if
    import onehot_event_gen_pkg::*;
#(
    parameter int N = N_REQ
);
    logic [N-1:0] onehot_out;
    logic         out_valid;
    logic         out_ready;

    modport master (output onehot_out, output out_valid, input out_ready);
    modport slave  (input onehot_out, input out_valid, output out_ready);
endinterface

// File: rtl/onehot_event_gen_sync_edge_det.sv
// Per-line synchroniser plus rising-edge detector; rise is a one-cycle pulse
// in the clk domain for every low-to-high transition of raw.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/onehot_event_gen.sv
// Turns raw request lines into queued rising-edge events, issued one at a
// time highest index first, so the encoder only ever sees one-hot or zero.
module onehot_event_gen
    import onehot_event_gen_pkg::*;
#(
    parameter int N           = N_REQ,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N-1:0]              raw_in,
    onehot_event_gen_if.master        evt,
    output logic [N-1:0]              pending,
    output logic                      overflow
);
    logic [N-1:0] rise;
    logic [N-1:0] pending_q;
    logic [N-1:0] onehot_q;
    logic         valid_q;
    logic         overflow_q;

    logic         slot_free;
    logic [N-1:0] sel;
    logic [N-1:0] issue_mask;
    logic [N-1:0] pending_d;
    logic         overflow_d;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_det [N-1:0] (
        .clk  (clk),
        .rst  (rst),
        .raw  (raw_in),
        .rise (rise)
    );

    // A new edge on the line being issued re-sets its bit: that is a fresh event.
    always_comb begin
        slot_free  = !valid_q || evt.out_ready;
        sel        = highest_onehot(pending_q);
        issue_mask = slot_free ? sel : '0;
        pending_d  = (pending_q & ~issue_mask) | rise;
        overflow_d = |(rise & pending_q & ~issue_mask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q  <= '0;
            onehot_q   <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            if (slot_free) begin
                onehot_q <= sel;
                valid_q  <= |pending_q;
            end
        end
    end

    assign evt.onehot_out = onehot_q;
    assign evt.out_valid  = valid_q;
    assign pending        = pending_q;
    assign overflow       = overflow_q;

    a_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(onehot_q));
    a_valid  : assert property (@(posedge clk) disable iff (rst) valid_q == (|onehot_q));
    a_hold   : assert property (@(posedge clk) disable iff (rst)
                   (valid_q && !evt.out_ready) |=> (valid_q && $stable(onehot_q)));

endmodule
